// File: rtl/frame_pingpong_buffer_if.sv
// Pixel-capture and line-readout bus for the ping-pong frame buffer.
// The master is the source/display side; the slave is the buffer itself.
interface frame_pingpong_buffer_if #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned H_PIX   = 330,
    parameter int unsigned LADDR_W = 10,
    parameter int unsigned CNT_W   = 16
);
    logic [PIX_W-1:0]       pix_in;
    logic                   pix_valid;
    logic                   freeze;
    logic                   line_req;
    logic [LADDR_W-1:0]     line_addr;
    logic [H_PIX*PIX_W-1:0] line_data;
    logic                   line_valid;
    logic                   line_err;
    logic                   frame_done;
    logic                   front_bank;
    logic [CNT_W-1:0]       frame_cnt;
    logic [CNT_W-1:0]       drop_cnt;

    modport master (
        output pix_in, pix_valid, freeze, line_req, line_addr,
        input  line_data, line_valid, line_err, frame_done, front_bank, frame_cnt, drop_cnt
    );

    modport slave (
        input  pix_in, pix_valid, freeze, line_req, line_addr,
        output line_data, line_valid, line_err, frame_done, front_bank, frame_cnt, drop_cnt
    );
endinterface

// File: rtl/frame_pingpong_buffer.sv
// Two-bank frame store: pixels are captured into the back bank, banks swap at frame end,
// and whole lines are read from the front bank so capture and scan-out never tear.
module frame_pingpong_buffer #(
    parameter int unsigned PIX_W   = 8,
    parameter int unsigned H_PIX   = 330,
    parameter int unsigned V_LINES = 110,
    parameter int unsigned LADDR_W = 10,
    parameter int unsigned CNT_W   = 16
) (
    input logic                     clk,
    input logic                     reset,
    frame_pingpong_buffer_if.slave  bus
);
    localparam int unsigned ColW  = (H_PIX > 1) ? $clog2(H_PIX) : 1;
    localparam int unsigned RowW  = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int unsigned LineW = H_PIX * PIX_W;

    logic [PIX_W-1:0] mem [2][V_LINES][H_PIX];

    logic [ColW-1:0]  wrCol;
    logic [RowW-1:0]  wrLine;
    logic             frontBank;
    logic [LineW-1:0] lineData;
    logic             lineValid;
    logic             lineErr;
    logic             frameDone;
    logic [CNT_W-1:0] frameCnt;
    logic [CNT_W-1:0] dropCnt;

    logic             lastCol;
    logic             lastLine;
    logic             addrOk;
    logic [RowW-1:0]  rdLine;
    logic [LineW-1:0] frontLine;

    assign lastCol  = (wrCol == ColW'(H_PIX - 1));
    assign lastLine = (wrLine == RowW'(V_LINES - 1));
    assign addrOk   = (32'(bus.line_addr) < V_LINES);
    assign rdLine   = bus.line_addr[RowW-1:0];

    // Pixel 0 lands in the MSBs of the assembled line.
    always_comb begin
        frontLine = '0;
        for (int c = 0; c < H_PIX; c++) begin
            frontLine[(H_PIX-1-c)*PIX_W +: PIX_W] = mem[frontBank][rdLine][c];
        end
    end

    // Storage is deliberately not reset; only the back bank is ever written.
    always_ff @(posedge clk) begin
        if (bus.pix_valid) begin
            mem[~frontBank][wrLine][wrCol] <= bus.pix_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrCol     <= '0;
            wrLine    <= '0;
            frontBank <= 1'b0;
            lineData  <= '0;
            lineValid <= 1'b0;
            lineErr   <= 1'b0;
            frameDone <= 1'b0;
            frameCnt  <= '0;
            dropCnt   <= '0;
        end else begin
            lineValid <= 1'b0;
            lineErr   <= 1'b0;
            frameDone <= 1'b0;

            if (bus.pix_valid) begin
                if (lastCol) begin
                    wrCol <= '0;
                    if (lastLine) begin
                        wrLine    <= '0;
                        frameDone <= 1'b1;
                        if (bus.freeze) begin
                            if (dropCnt != '1) dropCnt <= dropCnt + 1'b1;
                        end else begin
                            frontBank <= ~frontBank;
                            frameCnt  <= frameCnt + 1'b1;
                        end
                    end else begin
                        wrLine <= wrLine + 1'b1;
                    end
                end else begin
                    wrCol <= wrCol + 1'b1;
                end
            end

            // Reads in the swap cycle still use the pre-swap front bank.
            if (bus.line_req) begin
                if (addrOk) begin
                    lineData  <= frontLine;
                    lineValid <= 1'b1;
                end else begin
                    lineErr <= 1'b1;
                end
            end
        end
    end

    assign bus.line_data  = lineData;
    assign bus.line_valid = lineValid;
    assign bus.line_err   = lineErr;
    assign bus.frame_done = frameDone;
    assign bus.front_bank = frontBank;
    assign bus.frame_cnt  = frameCnt;
    assign bus.drop_cnt   = dropCnt;
endmodule

// File: tb/tb_frame_pingpong_buffer.sv
// Bench for frame_pingpong_buffer: directed frame sequences, a read-vector table,
// and randomized traffic, all checked against a linear-pixel-index reference model.
module tb_frame_pingpong_buffer;
    localparam int unsigned PIX_W   = 8;
    localparam int unsigned H_PIX   = 4;
    localparam int unsigned V_LINES = 3;
    localparam int unsigned LADDR_W = 2;
    localparam int unsigned CNT_W   = 16;
    localparam int unsigned LW      = H_PIX * PIX_W;
    localparam int unsigned FRAME   = H_PIX * V_LINES;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    frame_pingpong_buffer_if #(
        .PIX_W(PIX_W), .H_PIX(H_PIX), .LADDR_W(LADDR_W), .CNT_W(CNT_W)
    ) bus ();

    frame_pingpong_buffer #(
        .PIX_W(PIX_W), .H_PIX(H_PIX), .V_LINES(V_LINES), .LADDR_W(LADDR_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    // Reference model: frame position as a single pixel index.
    logic [PIX_W-1:0] m_mem [2][V_LINES][H_PIX];
    int unsigned      m_pos;
    bit               m_front;
    int unsigned      m_fcnt;
    int unsigned      m_dcnt;
    logic [LW-1:0]    m_ld;
    bit               m_lv, m_le, m_fd;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [LADDR_W-1:0] addr;
        logic [LW-1:0]      ld;
        bit                 lv;
        bit                 le;
    } rd_vec_t;
    rd_vec_t vecs [4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pos = 0; m_front = 0; m_fcnt = 0; m_dcnt = 0;
        m_ld = '0; m_lv = 0; m_le = 0; m_fd = 0;
    endtask

    task automatic compare_all();
        chk("line_data",  64'(bus.line_data),  64'(m_ld));
        chk("line_valid", 64'(bus.line_valid), 64'(m_lv));
        chk("line_err",   64'(bus.line_err),   64'(m_le));
        chk("frame_done", 64'(bus.frame_done), 64'(m_fd));
        chk("front_bank", 64'(bus.front_bank), 64'(m_front));
        chk("frame_cnt",  64'(bus.frame_cnt),  64'(m_fcnt));
        chk("drop_cnt",   64'(bus.drop_cnt),   64'(m_dcnt));
    endtask

    task automatic step(input bit pv, input logic [7:0] pix, input bit frz, input bit req,
                        input logic [LADDR_W-1:0] addr);
        logic [1:0] ln, cl;
        bus.pix_valid = pv;
        bus.pix_in    = pix;
        bus.freeze    = frz;
        bus.line_req  = req;
        bus.line_addr = addr;
        @(posedge clk);
        m_fd = 0; m_lv = 0; m_le = 0;
        if (req) begin
            if (int'(addr) < V_LINES) begin
                for (int c = 0; c < H_PIX; c++) m_ld[(H_PIX-1-c)*PIX_W +: PIX_W] = m_mem[m_front][addr][c];
                m_lv = 1;
            end else begin
                m_le = 1;
            end
        end
        if (pv) begin
            ln = 2'(m_pos / H_PIX);
            cl = 2'(m_pos % H_PIX);
            m_mem[!m_front][ln][cl] = pix;
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos = 0;
                m_fd  = 1;
                if (frz) begin
                    if (m_dcnt != (2**CNT_W) - 1) m_dcnt++;
                end else begin
                    m_front = !m_front;
                    m_fcnt  = (m_fcnt + 1) % (2**CNT_W);
                end
            end
        end
        #1;
        compare_all();
    endtask

    task automatic frame(input logic [7:0] base, input bit frz, input bit gap);
        for (int i = 0; i < FRAME; i++) begin
            if (gap) step(0, 8'($urandom), frz, 0, 0);
            step(1, base + 8'(i), frz, 0, 0);
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_line_data"},  64'(bus.line_data),  64'd0);
        chk({tag, "_line_valid"}, 64'(bus.line_valid), 64'd0);
        chk({tag, "_line_err"},   64'(bus.line_err),   64'd0);
        chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
        chk({tag, "_front_bank"}, 64'(bus.front_bank), 64'd0);
        chk({tag, "_frame_cnt"},  64'(bus.frame_cnt),  64'd0);
        chk({tag, "_drop_cnt"},   64'(bus.drop_cnt),   64'd0);
    endtask

    initial begin
        vecs[0] = '{addr: 2'd0, ld: 32'h50515253, lv: 1, le: 0};
        vecs[1] = '{addr: 2'd1, ld: 32'h54555657, lv: 1, le: 0};
        vecs[2] = '{addr: 2'd2, ld: 32'h58595A5B, lv: 1, le: 0};
        vecs[3] = '{addr: 2'd3, ld: 32'h58595A5B, lv: 0, le: 1};

        bus.pix_valid = 0; bus.pix_in = '0; bus.freeze = 0; bus.line_req = 0; bus.line_addr = '0;
        #2 reset = 1'b0;
        #1 check_zero_outputs("reset");
        model_reset();
        @(negedge clk) reset = 1'b1;

        // Frame 1 into bank 1, then swap.
        frame(8'h00, 0, 0);
        chk("f1_frame_done", 64'(bus.frame_done), 64'd1);
        chk("f1_front_bank", 64'(bus.front_bank), 64'd1);
        chk("f1_frame_cnt",  64'(bus.frame_cnt),  64'd1);
        step(0, 0, 0, 1, 2'd2);
        chk("f1_line2", 64'(bus.line_data), 64'h08090A0B);
        chk("f1_line2_valid", 64'(bus.line_valid), 64'd1);

        // Frame 2 while reading line 0 every cycle, including the swap cycle.
        for (int i = 0; i < FRAME; i++) begin
            step(1, 8'h10 + 8'(i), 0, 1, 2'd0);
            chk("f2_read_old_front", 64'(bus.line_data), 64'h00010203);
        end
        chk("f2_front_bank", 64'(bus.front_bank), 64'd0);
        step(0, 0, 0, 1, 2'd0);
        chk("f2_line0", 64'(bus.line_data), 64'h10111213);

        // Frozen frame is dropped.
        frame(8'h20, 1, 0);
        chk("frz_front_bank", 64'(bus.front_bank), 64'd0);
        chk("frz_drop_cnt",   64'(bus.drop_cnt),   64'd1);
        chk("frz_frame_cnt",  64'(bus.frame_cnt),  64'd2);
        step(0, 0, 0, 1, 2'd0);
        chk("frz_line0", 64'(bus.line_data), 64'h10111213);

        frame(8'h30, 0, 0);
        chk("unfrz_front_bank", 64'(bus.front_bank), 64'd1);
        step(0, 0, 0, 1, 2'd0);
        chk("unfrz_line0", 64'(bus.line_data), 64'h30313233);

        // Gapped writes, then table-driven reads including an out-of-range line.
        frame(8'h50, 0, 1);
        chk("gap_front_bank", 64'(bus.front_bank), 64'd0);
        chk("gap_frame_cnt",  64'(bus.frame_cnt),  64'd4);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 0, 1, vecs[i].addr);
            chk("vec_line_data",  64'(bus.line_data),  64'(vecs[i].ld));
            chk("vec_line_valid", 64'(bus.line_valid), 64'(vecs[i].lv));
            chk("vec_line_err",   64'(bus.line_err),   64'(vecs[i].le));
        end
        step(0, 0, 0, 0, 0);

        // Asynchronous reset in the middle of a frame.
        for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0, 1, 2'd1);
        #3 reset = 1'b0;
        bus.pix_valid = 0; bus.line_req = 0;
        #1 check_zero_outputs("midrst");
        model_reset();
        @(negedge clk) reset = 1'b1;
        frame(8'h40, 0, 0);
        chk("rst_frame_cnt",  64'(bus.frame_cnt),  64'd1);
        chk("rst_front_bank", 64'(bus.front_bank), 64'd1);
        step(0, 0, 0, 1, 2'd1);
        chk("rst_line1", 64'(bus.line_data), 64'h44454647);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 9) == 0,
                 1'($urandom), 2'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/frame_pingpong_buffer.md
Name: frame_pingpong_buffer

Overview:
Parametrised successor to the single-bank frame store. It captures a pixel stream into a back bank and swaps banks at frame end. The display side reads whole lines from the front bank, so capture and scan-out never tear. It sits between the pixel source and the line-based display driver, and adds a freeze mode plus frame and drop counters.

Parameters:
PIX_W, 8, bits per pixel
H_PIX, 330, pixels per line
V_LINES, 110, lines per frame (default frame = 36300 pixels)
LADDR_W, 10, width of line address; must satisfy 2^LADDR_W >= V_LINES
CNT_W, 16, width of frame and drop counters

Ports:
clk  in  1  system clock, all logic on posedge
reset  in  1  asynchronous, active-low reset
pix_in  in  PIX_W  incoming pixel
pix_valid  in  1  pixel strobe; one pixel written per cycle when high
freeze  in  1  hold current front bank; completed frames are not swapped in
line_req  in  1  request a line read from the front bank
line_addr  in  LADDR_W  requested line index
line_data  out  H_PIX*PIX_W  line; pixel 0 in MSBs (bits [0:PIX_W-1] numbering)
line_valid  out  1  one-cycle pulse, line_data updated
line_err  out  1  one-cycle pulse, line_addr out of range
frame_done  out  1  one-cycle pulse when the last pixel of a frame is written
front_bank  out  1  bank currently readable
frame_cnt  out  CNT_W  completed frames swapped to front, wraps
drop_cnt  out  CNT_W  completed frames discarded due to freeze, saturates

Behaviour:
- Reset (reset low, async): wr_col=0, wr_line=0, front_bank=0 (write bank=1), line_data=0, line_valid=0, line_err=0, frame_done=0, frame_cnt=0, drop_cnt=0. Memory contents are not cleared.
- Storage: 2 banks x V_LINES x H_PIX pixels.
- Write:
  - On pix_valid, pixel goes to back bank [wr_line][wr_col].
  - wr_col increments. At H_PIX-1 it wraps to 0 and wr_line increments.
  - At the last pixel (wr_line=V_LINES-1, wr_col=H_PIX-1), both wrap to 0 and frame_done pulses the next cycle.
  - pix_valid low: pointers hold.
- Swap at the last-pixel write:
  - freeze=0: front_bank toggles (visible the next cycle) and frame_cnt+1 (wraps).
  - freeze=1: no toggle, drop_cnt+1 (saturates at all-ones), and the next frame overwrites the same back bank.
  - freeze is sampled on the last-pixel cycle only.
- Read:
  - line_req with line_addr<V_LINES: line_data <= front bank line on the next edge and line_valid pulses. Latency is 1 cycle.
  - line_data holds between reads.
  - line_addr>=V_LINES: line_err pulses, line_valid stays 0, line_data holds.
  - Back-to-back requests are allowed every cycle.
- Simultaneous swap and read: a line_req in the swap cycle reads the pre-swap front bank. Reads from the next cycle onward use the new front.
- Reads never see the back bank. Writes never touch the front bank.
- Reset mid-frame: the partial frame is abandoned, pointers return to 0 and front_bank=0.

Test Plan:
- Bench params H_PIX=4, V_LINES=3, PIX_W=8. Reset, then stream 12 pixels 0x00..0x0B with pix_valid=1. Required: frame_done pulses once the cycle after pixel 0x0B, front_bank=1, frame_cnt=1. Then line_req with line_addr=2 gives line_data=0x08090A0B and line_valid one cycle later.
- Second frame 0x10..0x1B while reading line 0 every cycle. Required: line_data=0x00010203 throughout, including the swap cycle. Afterwards front_bank=0 and line 0 reads 0x10111213.
- Hold freeze=1 and stream frame 0x20..0x2B. Required: no swap, front_bank=0, drop_cnt=1, frame_cnt=2, line 0 still 0x10111213. Release freeze, stream 0x30..0x3B: front_bank=1, line 0 reads 0x30313233.
- Gapped writes: pix_valid toggled every other cycle for 12 pixels. Required: identical contents to the continuous case, and frame_done only after the 12th accepted pixel.
- line_addr=3 with line_req=1. Required: line_err pulses 1 cycle later, line_valid=0, line_data unchanged.
- Assert reset low after 5 pixels of a frame, asynchronously mid-cycle. Required: outputs zero immediately. After release, 12 pixels 0x40..0x4B complete a frame with frame_cnt=1 and line 1 reading 0x44454647.
